tmds_encoder_3ch: RTL and testbench

//  DVI 1.0 TMDS 8b/10b encoder for the three colour channels, plus the constant clock-channel word.

---
 rtl/tmds_pkg.sv | 24 ++
 rtl/tmds_encode_ch.sv | 121 ++++++++++++
 rtl/tmds_encoder_3ch.sv | 94 +++++++++
 tb/tb_tmds_encoder_3ch.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// Shared constants and helpers for the three-channel TMDS encoder.
package tmds_pkg;

    // Width of the signed running-disparity counter.
    localparam int CNT_W = 5;

    // Clock-channel word. The serializer sends it LSB first, so each pixel
    // period is five low bits followed by five high bits.
    localparam logic [9:0] CLK_PATTERN_DEF = 10'b1111100000;

    // Blanking control tokens, indexed by {C1, C0}.
    localparam logic [9:0] CTL_TOKEN [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

    // Number of ones in an 8-bit value.
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/tmds_encode_ch.sv
// Single-channel TMDS 8b/10b encoder with a fixed three-stage pipeline:
// S1 registers the pixel and its popcount, S2 builds the transition-minimised
// q_m word, S3 applies DC balancing (or emits a control token when de=0).
module tmds_encode_ch
    import tmds_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       de,
    input  logic       c0,
    input  logic       c1,
    input  logic [7:0] d,
    output logic [9:0] q
);

    // S1 state
    logic [7:0] d_s1_q, d_s1_d;
    logic [3:0] n1_s1_q, n1_s1_d;
    logic       de_s1_q, de_s1_d;
    logic [1:0] ctl_s1_q, ctl_s1_d;

    // S2 state
    logic [8:0] qm_s2_q, qm_s2_d;
    logic [3:0] n1_s2_q, n1_s2_d;
    logic [3:0] n0_s2_q, n0_s2_d;
    logic       de_s2_q, de_s2_d;
    logic [1:0] ctl_s2_q, ctl_s2_d;

    // S3 state
    logic [9:0]              q_q, q_d;
    logic signed [CNT_W-1:0] cnt_q, cnt_d;

    // S1: capture the inputs and count the ones in the pixel.
    always_comb begin
        d_s1_d   = d;
        n1_s1_d  = popcount8(d);
        de_s1_d  = de;
        ctl_s1_d = {c1, c0};
    end

    // S2: transition minimisation. Each q_m bit is the prefix parity of the
    // pixel, flipped on odd positions when the XNOR chain is selected.
    always_comb begin
        logic use_xnor;
        logic par;
        use_xnor = (n1_s1_q > 4'd4) || ((n1_s1_q == 4'd4) && !d_s1_q[0]);
        qm_s2_d  = '0;
        for (int i = 0; i < 8; i++) begin
            par = 1'b0;
            for (int j = 0; j <= i; j++) begin
                par = par ^ d_s1_q[j];
            end
            qm_s2_d[i] = par ^ (use_xnor & i[0]);
        end
        qm_s2_d[8] = ~use_xnor;
        n1_s2_d    = popcount8(qm_s2_d[7:0]);
        n0_s2_d    = 4'd8 - n1_s2_d;
        de_s2_d    = de_s1_q;
        ctl_s2_d   = ctl_s1_q;
    end

    // S3: DC-balance decision and running disparity update, or control token.
    always_comb begin
        logic signed [CNT_W-1:0] diff;
        diff  = $signed({1'b0, n1_s2_q}) - $signed({1'b0, n0_s2_q});
        q_d   = q_q;
        cnt_d = cnt_q;
        if (!de_s2_q) begin
            q_d   = CTL_TOKEN[ctl_s2_q];
            cnt_d = '0;
        end else if ((cnt_q == 5'sd0) || (n1_s2_q == n0_s2_q)) begin
            q_d   = {~qm_s2_q[8], qm_s2_q[8], qm_s2_q[8] ? qm_s2_q[7:0] : ~qm_s2_q[7:0]};
            cnt_d = qm_s2_q[8] ? (cnt_q + diff) : (cnt_q - diff);
        end else if (((cnt_q > 5'sd0) && (n1_s2_q > n0_s2_q)) ||
                     ((cnt_q < 5'sd0) && (n0_s2_q > n1_s2_q))) begin
            q_d   = {1'b1, qm_s2_q[8], ~qm_s2_q[7:0]};
            cnt_d = cnt_q + (qm_s2_q[8] ? 5'sd2 : 5'sd0) - diff;
        end else begin
            q_d   = {1'b0, qm_s2_q[8], qm_s2_q[7:0]};
            cnt_d = cnt_q - (qm_s2_q[8] ? 5'sd0 : 5'sd2) + diff;
        end
    end

    // Pipeline registers; reset leaves blanking with C1C0=00 in every stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_s1_q   <= '0;
            n1_s1_q  <= '0;
            de_s1_q  <= 1'b0;
            ctl_s1_q <= '0;
            qm_s2_q  <= '0;
            n1_s2_q  <= '0;
            n0_s2_q  <= '0;
            de_s2_q  <= 1'b0;
            ctl_s2_q <= '0;
            q_q      <= CTL_TOKEN[0];
            cnt_q    <= '0;
        end else begin
            d_s1_q   <= d_s1_d;
            n1_s1_q  <= n1_s1_d;
            de_s1_q  <= de_s1_d;
            ctl_s1_q <= ctl_s1_d;
            qm_s2_q  <= qm_s2_d;
            n1_s2_q  <= n1_s2_d;
            n0_s2_q  <= n0_s2_d;
            de_s2_q  <= de_s2_d;
            ctl_s2_q <= ctl_s2_d;
            q_q      <= q_d;
            cnt_q    <= cnt_d;
        end
    end

    assign q = q_q;

`ifndef SYNTHESIS
    // Running disparity is bounded to +/-8 by construction of the update rules.
    cnt_range_a: assert property (@(posedge clk) disable iff (!rst_n)
        (cnt_q >= -5'sd8) && (cnt_q <= 5'sd8));
`endif

endmodule

// File: rtl/tmds_encoder_3ch.sv
// DVI TMDS encoder for blue/green/red plus the constant clock-channel word.
// Optional build macro TMDS_BIST_EN adds a bist_en input that replaces all
// three pixel components with an internal ramp (increments while de=1,
// clears while de=0).
module tmds_encoder_3ch
    import tmds_pkg::*;
#(
    parameter logic [9:0] CLK_PATTERN = CLK_PATTERN_DEF,
    parameter logic       SYNC_INVERT = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
`ifdef TMDS_BIST_EN
    input  logic       bist_en,
`endif
    input  logic       de,
    input  logic       hsync,
    input  logic       vsync,
    input  logic [7:0] red,
    input  logic [7:0] green,
    input  logic [7:0] blue,
    output logic [9:0] data_b,
    output logic [9:0] data_g,
    output logic [9:0] data_r,
    output logic [9:0] data_c,
    output logic       de_o
);

    logic            hs_eff;
    logic            vs_eff;
    logic [2:0][7:0] pix;
    logic [2:0][1:0] ctl;
    logic [2:0][9:0] word;
    logic [2:0]      de_pipe_q, de_pipe_d;
    logic [9:0]      data_c_q, data_c_d;
`ifdef TMDS_BIST_EN
    logic [7:0]      ramp_q, ramp_d;
`endif

    // Sync polarity, per-channel control bits (only blue carries sync) and pixel source.
    always_comb begin
        hs_eff    = hsync ^ SYNC_INVERT;
        vs_eff    = vsync ^ SYNC_INVERT;
        ctl       = '0;
        ctl[0]    = {vs_eff, hs_eff};
        pix[0]    = blue;
        pix[1]    = green;
        pix[2]    = red;
`ifdef TMDS_BIST_EN
        ramp_d    = de ? (ramp_q + 8'd1) : 8'd0;
        if (bist_en) begin
            pix = {3{ramp_q}};
        end
`endif
        de_pipe_d = {de_pipe_q[1:0], de};
        data_c_d  = CLK_PATTERN;
    end

    // de alignment pipeline, clock-channel word and optional test ramp.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_pipe_q <= '0;
            data_c_q  <= CLK_PATTERN;
`ifdef TMDS_BIST_EN
            ramp_q    <= '0;
`endif
        end else begin
            de_pipe_q <= de_pipe_d;
            data_c_q  <= data_c_d;
`ifdef TMDS_BIST_EN
            ramp_q    <= ramp_d;
`endif
        end
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_ch
        tmds_encode_ch u_enc (
            .clk   (clk),
            .rst_n (rst_n),
            .de    (de),
            .c0    (ctl[gi][0]),
            .c1    (ctl[gi][1]),
            .d     (pix[gi]),
            .q     (word[gi])
        );
    end

    assign data_b = word[0];
    assign data_g = word[1];
    assign data_r = word[2];
    assign data_c = data_c_q;
    assign de_o   = de_pipe_q[2];

endmodule

// File: tb/tb_tmds_encoder_3ch.sv
// Scoreboard bench for tmds_encoder_3ch: stimulus pushes reference words,
// a monitor pops one entry per clock and compares, and also decodes every
// video word back to the pixel that produced it.
module tb_tmds_encoder_3ch;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       de = 1'b0;
    logic       hsync = 1'b0;
    logic       vsync = 1'b0;
    logic [7:0] red = '0;
    logic [7:0] green = '0;
    logic [7:0] blue = '0;
    logic [9:0] data_b, data_g, data_r, data_c;
    logic       de_o;
`ifdef TMDS_BIST_EN
    logic       bist_en = 1'b0;
`endif

    tmds_encoder_3ch dut (
        .clk    (clk),
        .rst_n  (rst_n),
`ifdef TMDS_BIST_EN
        .bist_en(bist_en),
`endif
        .de     (de),
        .hsync  (hsync),
        .vsync  (vsync),
        .red    (red),
        .green  (green),
        .blue   (blue),
        .data_b (data_b),
        .data_g (data_g),
        .data_r (data_r),
        .data_c (data_c),
        .de_o   (de_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] b, g, r;
        logic       de;
        logic [7:0] pb, pg, pr;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cnt_b = 0, cnt_g = 0, cnt_r = 0;
    logic mon_en = 1'b1;

    // Reference TMDS encoder working directly from the DVI rules with integers.
    function automatic logic [9:0] tmds_ref(input logic [7:0] d, input logic en,
                                            input logic [1:0] ctl, inout int cnt);
        int n1, qn1, qn0;
        logic xn;
        logic [8:0] qm;
        logic [9:0] w;
        if (!en) begin
            cnt = 0;
            case (ctl)
                2'b00:   w = 10'h354;
                2'b01:   w = 10'h0AB;
                2'b10:   w = 10'h154;
                default: w = 10'h2AB;
            endcase
            return w;
        end
        n1 = $countones(d);
        xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = ~xn;
        qn1 = $countones(qm[7:0]);
        qn0 = 8 - qn1;
        if (cnt == 0 || qn1 == qn0) begin
            w = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            cnt += qm[8] ? (qn1 - qn0) : (qn0 - qn1);
        end else if ((cnt > 0 && qn1 > qn0) || (cnt < 0 && qn0 > qn1)) begin
            w = {1'b1, qm[8], ~qm[7:0]};
            cnt += (qm[8] ? 2 : 0) + qn0 - qn1;
        end else begin
            w = {1'b0, qm[8], qm[7:0]};
            cnt += (qm[8] ? 0 : -2) + qn1 - qn0;
        end
        return w;
    endfunction

    // Receiver-side decode of a video word.
    function automatic logic [7:0] tmds_dec(input logic [9:0] w);
        logic [7:0] v, o;
        v = w[9] ? ~w[7:0] : w[7:0];
        o[0] = v[0];
        for (int i = 1; i < 8; i++) o[i] = w[8] ? (v[i] ^ v[i-1]) : ~(v[i] ^ v[i-1]);
        return o;
    endfunction

    task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_cycle(input logic e, input logic hs, input logic vs,
                              input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        exp_t x;
        x.b  = tmds_ref(b, e, {vs, hs}, cnt_b);
        x.g  = tmds_ref(g, e, 2'b00, cnt_g);
        x.r  = tmds_ref(r, e, 2'b00, cnt_r);
        x.de = e;
        x.pb = b;
        x.pg = g;
        x.pr = r;
        sb.push_back(x);
    endtask

    // One pixel clock of stimulus; ovr >= 0 replaces the expected blue word with a fixed value.
    task automatic step(input logic e, input logic hs, input logic vs,
                        input logic [7:0] r, input logic [7:0] g, input logic [7:0] b, input int ovr);
        @(negedge clk);
        de = e; hsync = hs; vsync = vs; red = r; green = g; blue = b;
        push_cycle(e, hs, vs, r, g, b);
        if (ovr >= 0) sb[sb.size()-1].b = ovr[9:0];
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_data_b"}, data_b, 10'h354);
        chk({tag, "_data_g"}, data_g, 10'h354);
        chk({tag, "_data_r"}, data_r, 10'h354);
        chk({tag, "_data_c"}, data_c, 10'h3E0);
        chk({tag, "_de_o"}, {9'b0, de_o}, 10'h000);
    endtask

    // Assert reset between clock edges, confirm immediate reset outputs, then release.
    task automatic do_reset(input string tag);
        exp_t x;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs({tag, "_async"});
        de = 0; hsync = 0; vsync = 0; red = 0; green = 0; blue = 0;
        sb.delete();
        cnt_b = 0; cnt_g = 0; cnt_r = 0;
        repeat (2) @(negedge clk);
        check_reset_outputs({tag, "_held"});
        x.b = 10'h354; x.g = 10'h354; x.r = 10'h354; x.de = 1'b0;
        x.pb = 0; x.pg = 0; x.pr = 0;
        sb.push_back(x);
        sb.push_back(x);
        @(negedge clk);
        rst_n = 1'b1;
        push_cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    endtask

    // Monitor: one output word per channel per clock once out of reset.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && mon_en) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_underflow: got no entry expected one");
                end else begin
                    x = sb.pop_front();
                    chk("data_b", data_b, x.b);
                    chk("data_g", data_g, x.g);
                    chk("data_r", data_r, x.r);
                    chk("data_c", data_c, 10'h3E0);
                    chk("de_o", {9'b0, de_o}, {9'b0, x.de});
                    if (x.de) begin
                        chk("decode_b", {2'b0, tmds_dec(data_b)}, {2'b0, x.pb});
                        chk("decode_g", {2'b0, tmds_dec(data_g)}, {2'b0, x.pg});
                        chk("decode_r", {2'b0, tmds_dec(data_r)}, {2'b0, x.pr});
                    end
                end
            end
        end
    end

    initial begin
        logic e;
        logic [7:0] pr, pg, pb;
        do_reset("reset");

        // Control tokens on blue; green and red stay on the 00 token.
        step(0, 1, 0, 8'h12, 8'h34, 8'h56, 10'h0AB);
        step(0, 1, 1, 8'h00, 8'h00, 8'h00, 10'h2AB);
        step(0, 0, 1, 8'hFF, 8'hFF, 8'hFF, 10'h154);
        step(0, 0, 0, 8'h00, 8'h00, 8'h00, 10'h354);

        // Black after blanking: cnt walks -8, +2, -6.
        step(1, 0, 0, 8'h00, 8'h00, 8'h00, 10'h100);
        step(1, 0, 0, 8'h00, 8'h00, 8'h00, 10'h3FF);
        step(1, 0, 0, 8'h00, 8'h00, 8'h00, 10'h100);

        // Random traffic in three de regimes: long lines, toggling, random.
        for (int i = 0; i < 9000; i++) begin
            case ((i / 1000) % 3)
                0:       e = ($urandom_range(0, 15) != 0);
                1:       e = i[0];
                default: e = $urandom_range(0, 1) != 0;
            endcase
            pr = $urandom_range(0, 255);
            pg = $urandom_range(0, 255);
            pb = $urandom_range(0, 255);
            if ($urandom_range(0, 7) == 0) pb = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
            step(e, $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0, pr, pg, pb, -1);
        end

        // Reset mid-line while de=1 with nonzero disparity, then black restarts from cnt=0.
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, $urandom_range(0, 255), $urandom_range(0, 255), 8'h00, -1);
        end
        do_reset("midline");
        step(1, 0, 0, 8'h00, 8'h00, 8'h00, 10'h100);
        step(1, 0, 0, 8'h00, 8'h00, 8'h00, 10'h3FF);
        step(1, 0, 0, 8'h00, 8'h00, 8'h00, 10'h100);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 8'h00, 8'h00, 8'h00, -1);

        @(negedge clk);
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
